// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with 16x oversampling and 3-sample majority vote
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int CW = $clog2(DIV);
  typedef enum logic [3:0] {IDLE = 4'b0001, START = 4'b0010, DATA = 4'b0100, STOP = 4'b1000} state_t;
  state_t state;
  logic s1, rxs, rxs_d, m7, m8;
  logic [CW-1:0] cnt;
  logic [3:0] sub;
  logic [2:0] bitcnt;
  logic [7:0] shift;
  logic tick, eval, wrap, maj;
  // "tick k" is the tick that moves the sub-bit counter to k
  assign tick = cnt == CW'(DIV - 1);
  assign eval = tick && sub == 4'd8;
  assign wrap = tick && sub == 4'd15;
  assign maj = (m7 & m8) | (m7 & rxs) | (m8 & rxs);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      s1 <= 1'b1;
      rxs <= 1'b1;
      rxs_d <= 1'b1;
      m7 <= 1'b0;
      m8 <= 1'b0;
      cnt <= '0;
      sub <= '0;
      bitcnt <= '0;
      shift <= '0;
      data <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      s1 <= rxd;
      rxs <= s1;
      rxs_d <= rxs;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) sub <= sub + 4'd1;
      if (tick && sub == 4'd6) m7 <= rxs;
      if (tick && sub == 4'd7) m8 <= rxs;
      case (state)
        IDLE: begin
          cnt <= '0;
          sub <= '0;
          bitcnt <= '0;
          if (rxs_d && !rxs) begin
            state <= START;
            busy <= 1'b1;
          end
        end
        START:
          if (eval && maj) begin
            state <= IDLE;
            busy <= 1'b0;
          end else if (wrap) state <= DATA;
        DATA: begin
          if (eval) shift <= {maj, shift[7:1]};
          if (wrap) begin
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= STOP;
          end
        end
        STOP:
          if (eval) begin
            state <= IDLE;
            busy <= 1'b0;
            if (maj) begin
              data <= shift;
              data_valid <= 1'b1;
            end else frame_err <= 1'b1;
          end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule
